obi_axi_lite_bridge: RTL and testbench

//  OBI subordinate to AXI4-Lite manager bridge, single clock domain, with up to MaxOutstanding

---
 rtl/obi_axi_lite_bridge.sv | 181 ++++++++++++++++++
 tb/tb_obi_axi_lite_bridge.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_axi_lite_bridge.sv
// OBI subordinate to AXI4-Lite manager bridge with up to MaxOutstanding transactions in flight.
// An order FIFO of read/write flags steers B/R acceptance so OBI responses follow grant order.
module obi_axi_lite_bridge #(
  parameter int unsigned  AddrWidth      = 32,
  parameter int unsigned  DataWidth      = 32,
  parameter int unsigned  MaxOutstanding = 4,
  parameter logic [2:0]   AxiProt        = 3'b0,
  localparam int unsigned StrbWidth      = DataWidth / 8,
  localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 obi_req_i,
  output logic                 obi_gnt_o,
  input  logic [AddrWidth-1:0] obi_addr_i,
  input  logic                 obi_we_i,
  input  logic [StrbWidth-1:0] obi_be_i,
  input  logic [DataWidth-1:0] obi_wdata_i,
  output logic                 obi_rvalid_o,
  output logic [DataWidth-1:0] obi_rdata_o,
  output logic                 obi_err_o,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output logic [AddrWidth-1:0] aw_addr_o,
  output logic [2:0]           aw_prot_o,
  output logic                 w_valid_o,
  input  logic                 w_ready_i,
  output logic [DataWidth-1:0] w_data_o,
  output logic [StrbWidth-1:0] w_strb_o,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  input  logic [1:0]           b_resp_i,
  output logic                 ar_valid_o,
  input  logic                 ar_ready_i,
  output logic [AddrWidth-1:0] ar_addr_o,
  output logic [2:0]           ar_prot_o,
  input  logic                 r_valid_i,
  output logic                 r_ready_o,
  input  logic [DataWidth-1:0] r_data_i,
  input  logic [1:0]           r_resp_i,
  output logic [CntW-1:0]      outstanding_o,
  output logic [15:0]          err_cnt_o,
  input  logic                 err_cnt_clr_i
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [AddrWidth-1:0]      addr_q, addr_d;
  logic [DataWidth-1:0]      wdata_q, wdata_d;
  logic [StrbWidth-1:0]      be_q, be_d;
  logic                      aw_pend_q, aw_pend_d;
  logic                      w_pend_q, w_pend_d;
  logic                      ar_pend_q, ar_pend_d;
  logic [MaxOutstanding-1:0] fifo_q, fifo_d;
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      rvalid_q, rvalid_d;
  logic [DataWidth-1:0]      rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic [15:0]               err_cnt_q, err_cnt_d;

  logic issue_free, gnt, head_we, fifo_empty, b_hs, r_hs, pop, rsp_err;
  logic unused_resp;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // The stage may be reloaded in the same cycle its last pending channel handshakes.
  assign issue_free = !(aw_pend_q && !aw_ready_i) && !(w_pend_q && !w_ready_i) &&
                      !(ar_pend_q && !ar_ready_i);
  assign gnt        = obi_req_i && rst_ni && (cnt_q < CntW'(MaxOutstanding)) && issue_free;

  assign fifo_empty = (cnt_q == '0);
  assign head_we    = fifo_q[rd_ptr_q];
  assign b_ready_o  = !fifo_empty && head_we;
  assign r_ready_o  = !fifo_empty && !head_we;
  assign b_hs       = b_valid_i && b_ready_o;
  assign r_hs       = r_valid_i && r_ready_o;
  assign pop        = b_hs || r_hs;
  assign rsp_err    = b_hs ? b_resp_i[1] : r_resp_i[1];
  assign unused_resp = ^{b_resp_i[0], r_resp_i[0]};

  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    aw_pend_d = aw_pend_q && !aw_ready_i;
    w_pend_d  = w_pend_q && !w_ready_i;
    ar_pend_d = ar_pend_q && !ar_ready_i;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;

    if (gnt) begin
      addr_d           = obi_addr_i;
      wdata_d          = obi_wdata_i;
      be_d             = obi_be_i;
      aw_pend_d        = obi_we_i;
      w_pend_d         = obi_we_i;
      ar_pend_d        = !obi_we_i;
      fifo_d[wr_ptr_q] = obi_we_i;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({gnt, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    rvalid_d = pop;
    rdata_d  = r_hs ? r_data_i : '0;
    err_d    = pop && rsp_err;

    // Clear wins over a coincident error so software never loses a clear.
    if (err_cnt_clr_i) begin
      err_cnt_d = '0;
    end else if (pop && rsp_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      ar_pend_q <= 1'b0;
      fifo_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      ar_pend_q <= ar_pend_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign obi_gnt_o     = gnt;
  assign obi_rvalid_o  = rvalid_q;
  assign obi_rdata_o   = rdata_q;
  assign obi_err_o     = err_q;
  assign aw_valid_o    = aw_pend_q;
  assign aw_addr_o     = addr_q;
  assign aw_prot_o     = AxiProt;
  assign w_valid_o     = w_pend_q;
  assign w_data_o      = wdata_q;
  assign w_strb_o      = be_q;
  assign ar_valid_o    = ar_pend_q;
  assign ar_addr_o     = addr_q;
  assign ar_prot_o     = AxiProt;
  assign outstanding_o = cnt_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_obi_axi_lite_bridge.sv
// Bench for obi_axi_lite_bridge: queue-based OBI manager, AXI-Lite subordinate and
// grant-order response model; directed scenarios followed by a randomized mix.
module tb_obi_axi_lite_bridge;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        obi_req_i = 1'b0, obi_gnt_o, obi_we_i = 1'b0;
  logic [31:0] obi_addr_i = '0, obi_wdata_i = '0, obi_rdata_o;
  logic [3:0]  obi_be_i = '0;
  logic        obi_rvalid_o, obi_err_o;
  logic        aw_valid_o, aw_ready_i = 1'b0, w_valid_o, w_ready_i = 1'b0;
  logic [31:0] aw_addr_o, ar_addr_o, w_data_o, r_data_i = '0;
  logic [2:0]  aw_prot_o, ar_prot_o;
  logic [3:0]  w_strb_o;
  logic        b_valid_i = 1'b0, b_ready_o, ar_valid_o, ar_ready_i = 1'b0;
  logic        r_valid_i = 1'b0, r_ready_o;
  logic [1:0]  b_resp_i = '0, r_resp_i = '0;
  logic [2:0]  outstanding_o;
  logic [15:0] err_cnt_o;
  logic        err_cnt_clr_i = 1'b0;

  obi_axi_lite_bridge #(.AddrWidth(32), .DataWidth(32), .MaxOutstanding(4), .AxiProt(3'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i), .obi_we_i(obi_we_i),
    .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i), .obi_rvalid_o(obi_rvalid_o),
    .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_prot_o(aw_prot_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_prot_o(ar_prot_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
    .outstanding_o(outstanding_o), .err_cnt_o(err_cnt_o), .err_cnt_clr_i(err_cnt_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  txn_t        req_q[$], ord_q[$], w_exp[$];
  logic [31:0] aw_exp[$], ar_exp[$], rd_acc[$], wr_acc[$];
  int          w_done = 0, out_model = 0, gnt_total = 0, rsp_total = 0;
  int          aw_total = 0, w_total = 0;
  logic [15:0] err_model = '0;
  logic        hs_prev = 1'b0, gnt_seen = 1'b0, clr_arm = 1'b0, clr_req = 1'b0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  bit          rand_rdy = 0, rand_req = 0, rand_clr = 0;
  bit          aw_en = 1, w_en = 1, ar_en = 1, b_en = 1, r_en = 1;

  // The subordinate's memory image and error map are pure functions of the address.
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDFADBEEF;
  endfunction

  function automatic logic [1:0] resp_fn(input logic [31:0] a);
    if (a[9])       return 2'b10;
    else if (a[10]) return 2'b11;
    else if (a[11]) return 2'b01;
    else            return 2'b00;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic monitorCycle();
    txn_t        t;
    logic [31:0] a;
    logic        hs, hs_err;
    hs = 1'b0;
    hs_err = 1'b0;
    checkOutput("outstanding", 32'(outstanding_o), 32'(out_model));
    checkOutput("err_cnt", 32'(err_cnt_o), 32'(err_model));
    checkOutput("rvalid_latency", 32'(obi_rvalid_o), 32'(hs_prev));
    if (obi_rvalid_o) begin
      checkOutput("rsp_expected", 32'(ord_q.size() != 0), 1);
      if (ord_q.size() != 0) begin
        t = ord_q.pop_front();
        checkOutput("rsp_rdata", obi_rdata_o, t.we ? 32'h0 : rd_fn(t.addr));
        checkOutput("rsp_err", 32'(obi_err_o), 32'(resp_fn(t.addr) >> 1));
      end
      rsp_total++;
      last_rdata = obi_rdata_o;
      last_err   = obi_err_o;
    end
    if (obi_req_i && obi_gnt_o) begin
      t = req_q.pop_front();
      ord_q.push_back(t);
      if (t.we) begin
        aw_exp.push_back(t.addr);
        w_exp.push_back(t);
      end else begin
        ar_exp.push_back(t.addr);
      end
      out_model++;
      gnt_total++;
      gnt_seen = 1'b1;
    end
    if (aw_valid_o && aw_ready_i) begin
      aw_total++;
      checkOutput("aw_expected", 32'(aw_exp.size() != 0), 1);
      if (aw_exp.size() != 0) begin
        a = aw_exp.pop_front();
        checkOutput("aw_addr", aw_addr_o, a);
        checkOutput("aw_prot", 32'(aw_prot_o), 0);
        wr_acc.push_back(a);
      end
    end
    if (w_valid_o && w_ready_i) begin
      w_total++;
      checkOutput("w_expected", 32'(w_exp.size() != 0), 1);
      if (w_exp.size() != 0) begin
        t = w_exp.pop_front();
        checkOutput("w_data", w_data_o, t.wdata);
        checkOutput("w_strb", 32'(w_strb_o), 32'(t.be));
        w_done++;
      end
    end
    if (ar_valid_o && ar_ready_i) begin
      checkOutput("ar_expected", 32'(ar_exp.size() != 0), 1);
      if (ar_exp.size() != 0) begin
        a = ar_exp.pop_front();
        checkOutput("ar_addr", ar_addr_o, a);
        checkOutput("ar_prot", 32'(ar_prot_o), 0);
        rd_acc.push_back(a);
      end
    end
    if (b_valid_i && b_ready_o) begin
      a = wr_acc.pop_front();
      w_done--;
      hs = 1'b1;
      hs_err = resp_fn(a) >= 2'b10;
    end
    if (r_valid_i && r_ready_o) begin
      a = rd_acc.pop_front();
      hs = 1'b1;
      hs_err = resp_fn(a) >= 2'b10;
    end
    if (hs) begin
      out_model--;
      if (clr_arm) begin
        err_cnt_clr_i = 1'b1;
        clr_arm = 1'b0;
      end
    end
    if (err_cnt_clr_i) err_model = '0;
    else if (hs && hs_err && err_model != 16'hFFFF) err_model = err_model + 16'd1;
    hs_prev = hs;
  endtask

  task automatic driveInputs();
    txn_t t;
    logic hold;
    if (!rst_ni) begin
      obi_req_i = 0; aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
      b_valid_i = 0; r_valid_i = 0; err_cnt_clr_i = 0;
      return;
    end
    hold = obi_req_i && !gnt_seen;
    gnt_seen = 1'b0;
    if (req_q.size() != 0 && (hold || !rand_req || $urandom_range(3) != 0)) begin
      t = req_q[0];
      obi_req_i = 1'b1; obi_we_i = t.we; obi_addr_i = t.addr;
      obi_wdata_i = t.wdata; obi_be_i = t.be;
    end else begin
      obi_req_i = 1'b0;
    end
    aw_ready_i = rand_rdy ? 1'($urandom_range(1)) : aw_en;
    w_ready_i  = rand_rdy ? 1'($urandom_range(1)) : w_en;
    ar_ready_i = rand_rdy ? 1'($urandom_range(1)) : ar_en;
    b_valid_i  = b_en && wr_acc.size() != 0 && w_done > 0 && (!rand_rdy || $urandom_range(1) == 1);
    b_resp_i   = b_valid_i ? resp_fn(wr_acc[0]) : 2'b00;
    r_valid_i  = r_en && rd_acc.size() != 0 && (!rand_rdy || $urandom_range(1) == 1);
    r_data_i   = r_valid_i ? rd_fn(rd_acc[0]) : 32'h0;
    r_resp_i   = r_valid_i ? resp_fn(rd_acc[0]) : 2'b00;
    err_cnt_clr_i = clr_req || (rand_clr && $urandom_range(15) == 0);
  endtask

  // One clock: observe mid-cycle (negedge), then drive just after the rising edge.
  task automatic applyStimulus();
    @(negedge clk_i);
    if (rst_ni) monitorCycle();
    @(posedge clk_i);
    #1;
    driveInputs();
  endtask

  task automatic pushTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.be = be;
    req_q.push_back(t);
  endtask

  task automatic waitDrain(input int bound, input string tag);
    int n;
    n = 0;
    while ((req_q.size() != 0 || ord_q.size() != 0) && n < bound) begin
      applyStimulus();
      n++;
    end
    checkOutput({tag, "_drain"}, 32'(req_q.size() + ord_q.size()), 0);
  endtask

  initial begin
    int g0, r0, aw0, w0;
    $display("[TB] start");
    #2;
    checkOutput("rst_rvalid", 32'(obi_rvalid_o), 0);
    checkOutput("rst_outstanding", 32'(outstanding_o), 0);
    checkOutput("rst_aw_valid", 32'(aw_valid_o), 0);
    checkOutput("rst_ar_valid", 32'(ar_valid_o), 0);
    checkOutput("rst_err_cnt", 32'(err_cnt_o), 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Single read, R delayed after AR acceptance.
    r_en = 0;
    pushTxn(1'b0, 32'h100, 32'h0, 4'hF);
    repeat (4) applyStimulus();
    r_en = 1;
    waitDrain(50, "t1");
    checkOutput("t1_rdata", last_rdata, 32'hDEADBEEF);
    checkOutput("t1_err", 32'(last_err), 0);

    // Write with W accepted well before AW; B returns SLVERR.
    aw0 = aw_total; w0 = w_total;
    aw_en = 0;
    pushTxn(1'b1, 32'h200, 32'h12345678, 4'hF);
    repeat (5) applyStimulus();
    aw_en = 1;
    waitDrain(50, "t2");
    checkOutput("t2_aw_count", 32'(aw_total - aw0), 1);
    checkOutput("t2_w_count", 32'(w_total - w0), 1);
    checkOutput("t2_err", 32'(last_err), 1);
    checkOutput("t2_err_cnt", 32'(err_cnt_o), 1);

    // Six back-to-back reads with R withheld: only four may be granted.
    g0 = gnt_total; r0 = rsp_total;
    r_en = 0;
    for (int i = 0; i < 6; i++) pushTxn(1'b0, 32'h1000 + 32'(i * 4), 32'h0, 4'hF);
    repeat (10) applyStimulus();
    checkOutput("t3_grants", 32'(gnt_total - g0), 4);
    checkOutput("t3_full", 32'(outstanding_o), 4);
    checkOutput("t3_stall_gnt", 32'(obi_gnt_o), 0);
    r_en = 1;
    waitDrain(100, "t3");
    checkOutput("t3_rsps", 32'(rsp_total - r0), 6);

    // Write then read; R arrives first but must wait behind B.
    b_en = 0;
    pushTxn(1'b1, 32'h40, 32'hCAFEF00D, 4'h3);
    pushTxn(1'b0, 32'h80, 32'h0, 4'hF);
    repeat (8) applyStimulus();
    checkOutput("t4_r_blocked", 32'(r_ready_o), 0);
    checkOutput("t4_outstanding", 32'(outstanding_o), 2);
    b_en = 1;
    waitDrain(50, "t4");

    // Randomized mix with random ready/valid timing and occasional counter clears.
    rand_rdy = 1; rand_req = 1; rand_clr = 1;
    for (int i = 0; i < 300; i++)
      pushTxn(1'($urandom_range(1)), $urandom & 32'h0000_0FFC, $urandom, 4'($urandom_range(15)));
    waitDrain(20000, "rand");
    rand_rdy = 0; rand_req = 0; rand_clr = 0;

    // Saturation: clear, then 65536 erroring writes; then clear coincident with an error.
    clr_req = 1;
    applyStimulus();
    clr_req = 0;
    applyStimulus();
    for (int i = 0; i < 65536; i++) pushTxn(1'b1, 32'h200, 32'(i), 4'hF);
    waitDrain(80000, "t5");
    checkOutput("t5_saturated", 32'(err_cnt_o), 32'hFFFF);
    clr_arm = 1;
    pushTxn(1'b1, 32'h200, 32'h0, 4'hF);
    waitDrain(50, "t5b");
    checkOutput("t5_clr_wins", 32'(err_cnt_o), 0);

    // Reset with three reads in flight; afterwards a fresh read completes.
    pushTxn(1'b1, 32'h600, 32'h0, 4'hF);
    waitDrain(50, "t6a");
    r_en = 0; b_en = 0;
    for (int i = 0; i < 3; i++) pushTxn(1'b0, 32'h1100 + 32'(i * 4), 32'h0, 4'hF);
    repeat (6) applyStimulus();
    checkOutput("t6_outstanding", 32'(outstanding_o), 3);
    rst_ni = 1'b0;
    #1;
    checkOutput("t6_aw_valid", 32'(aw_valid_o), 0);
    checkOutput("t6_w_valid", 32'(w_valid_o), 0);
    checkOutput("t6_ar_valid", 32'(ar_valid_o), 0);
    checkOutput("t6_rvalid", 32'(obi_rvalid_o), 0);
    checkOutput("t6_err", 32'(obi_err_o), 0);
    checkOutput("t6_rdata", obi_rdata_o, 0);
    checkOutput("t6_cnt", 32'(outstanding_o), 0);
    checkOutput("t6_err_cnt", 32'(err_cnt_o), 0);
    checkOutput("t6_b_ready", 32'(b_ready_o), 0);
    checkOutput("t6_r_ready", 32'(r_ready_o), 0);
    req_q.delete(); ord_q.delete(); w_exp.delete(); aw_exp.delete(); ar_exp.delete();
    rd_acc.delete(); wr_acc.delete();
    w_done = 0; out_model = 0; err_model = '0; hs_prev = 0; gnt_seen = 0; clr_arm = 0;
    repeat (2) applyStimulus();
    rst_ni = 1'b1;
    r_en = 1; b_en = 1;
    r0 = rsp_total;
    pushTxn(1'b0, 32'h300, 32'h0, 4'hF);
    waitDrain(50, "t6");
    checkOutput("t6_rsps", 32'(rsp_total - r0), 1);
    checkOutput("t6_rdata_after", last_rdata, rd_fn(32'h300));
    repeat (3) applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
